// File: rtl/mul_iterative_pkg.sv
// mul_iterative_pkg
//   Shared definitions for the iterative shift-add multiplier: FSM state
//   encodings and the default operand width.
package mul_iterative_pkg;

  localparam int MUL_WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'd0,
    MUL_ST_BUSY = 2'd1,
    MUL_ST_DONE = 2'd2
  } mul_state_e;

endpackage : mul_iterative_pkg

// File: rtl/mul_iterative_if.sv
// mul_iterative_if
//   Request/result bundle between execute-stage control and the multiplier.
//   Ports:
//     start      control -> mul  level request (mult_start)
//     operand_a  control -> mul  multiplicand (Rn)
//     operand_b  control -> mul  multiplier (Rm)
//     product    mul -> control  low WIDTH bits of a*b
//     done       mul -> control  one-cycle completion pulse
//     busy       mul -> control  operation in flight (BUSY or DONE)
//   WIDTH must match the WIDTH of the mul_iterative instance it connects to.
interface mul_iterative_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] product;
  logic             done;
  logic             busy;

  modport master (
    output start, operand_a, operand_b,
    input  product, done, busy
  );

  modport slave (
    input  start, operand_a, operand_b,
    output product, done, busy
  );
endinterface : mul_iterative_if

// File: rtl/mul_iterative_shift_add_step.sv
// mul_iterative_shift_add_step
//   One combinational shift-add iteration.
//   Ports:
//     acc_i / a_i / b_i  current accumulator, shifted multiplicand, multiplier
//     acc_o / a_o / b_o  values after this step
//   The add is truncated to WIDTH bits; only the low product bits matter.
module mul_iterative_shift_add_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  assign acc_o = b_i[0] ? (acc_i + a_i) : acc_i;
  assign a_o   = a_i << 1;
  assign b_o   = b_i >> 1;

endmodule : mul_iterative_shift_add_step

// File: rtl/mul_iterative.sv
// mul_iterative
//   Multi-cycle shift-add multiplier for the MUL instruction. Produces the low
//   WIDTH bits of operand_a * operand_b (identical for signed and unsigned).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mul_iterative_if.slave (start, operands in; product, done, busy out)
//   Optional feature: define MUL_EARLY_TERM_EN to leave BUSY as soon as the
//   remaining multiplier bits are all zero (first BUSY cycle always runs).
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on acceptance
//   BUSY  | one shift-add step per cycle
//   DONE  | done pulse, product valid; returns to IDLE unconditionally
module mul_iterative
  import mul_iterative_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_iterative_if.slave bus
);

  localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] acc_nxt, a_nxt, b_nxt;
  logic             last_step;

  mul_iterative_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_o (acc_nxt),
    .a_o   (a_nxt),
    .b_o   (b_nxt)
  );

`ifdef MUL_EARLY_TERM_EN
  // b_nxt == 0 means every remaining step would add nothing.
  assign last_step = (count_q == LAST_CNT) || (b_nxt == '0);
`else
  assign last_step = (count_q == LAST_CNT);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MUL_ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MUL_ST_IDLE: if (bus.start) state_d = MUL_ST_BUSY;
      MUL_ST_BUSY: if (last_step) state_d = MUL_ST_DONE;
      MUL_ST_DONE: state_d = MUL_ST_IDLE;
      default:     state_d = MUL_ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      MUL_ST_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          a_d     = bus.operand_a;
          b_d     = bus.operand_b;
          count_d = '0;
        end
      end
      MUL_ST_BUSY: begin
        acc_d = acc_nxt;
        a_d   = a_nxt;
        b_d   = b_nxt;
        // Hold on the final step so the counter never wraps.
        if (!last_step) count_d = count_q + 1'b1;
        else            product_d = acc_nxt;
      end
      default: ;
    endcase
    done_d = (state_d == MUL_ST_DONE);
    busy_d = (state_d != MUL_ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.product = product_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule : mul_iterative

// File: doc/mul_iterative.md
# mul_iterative

Multi-cycle shift-add integer multiplier for the LEGv8 non-pipelined core's execute stage. It computes the low WIDTH bits of `operand_a * operand_b` for the MUL instruction. Decode control holds `mult_start` and freezes the PC (branch_op 110) until this block returns `multiplier_done`. On that cycle control asserts `reg_write` with `execute_result_loc = 1`, and the register file captures `product`.

## Interface
- `WIDTH`, 64, operand and product width. Must be ≥ 2.
- `clk`  in  1  Single clock. Everything is rising-edge.
- `rst_n`  in  1  Reset: one clock; reset is asynchronous and active-low.
- `start`  in  1  Level request from control (`mult_start`). Sampled only in IDLE.
- `operand_a`  in  WIDTH  Multiplicand (Rn read data). Latched when `start` is accepted.
- `operand_b`  in  WIDTH  Multiplier (Rm read data). Latched when `start` is accepted.
- `product`  out  WIDTH  Low WIDTH bits of a×b. Valid while `done` is high, and held until the next accepted start.
- `done`  out  1  One-cycle pulse; drives control's `multiplier_done`.
- `busy`  out  1  High in BUSY and DONE.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE, `start` = 0: no change.
- IDLE, `start` = 1:
  - Latch `a_reg ← operand_a`, `b_reg ← operand_b`.
  - Clear `acc` and `count` to 0.
  - Go to BUSY.
- BUSY, one step per cycle:
  - If `b_reg[0]`, `acc ← acc + a_reg`. The sum is truncated to WIDTH bits and the carry is discarded.
  - `a_reg ← a_reg << 1`, `b_reg ← b_reg >> 1` (logical), `count ← count + 1`.
  - Exit to DONE when `count == WIDTH-1`, or on the early-exit condition (see Configuration). Otherwise stay in BUSY.
- DONE:
  - `done` = 1 for exactly this cycle.
  - `product` = `acc`.
  - Unconditionally return to IDLE.
- `start` is ignored in BUSY and in DONE. Control drops `start` combinationally when `done` is high. A MUL issued immediately afterwards is therefore seen only in the following IDLE cycle.
- Signedness: the low WIDTH bits are identical for signed and unsigned operands, so no sign handling is done.
- Operand changes after acceptance have no effect.
- Reset, asynchronous, at any time including mid-operation:
  - State goes to IDLE.
  - `acc`, `a_reg`, `b_reg`, `count`, `product` are cleared to 0.
  - `done` = 0, `busy` = 0.
  - The interrupted operation is lost and produces no `done`.
- `count` is `$clog2(WIDTH)` bits wide and never wraps within one operation.

## Timing
- Cycle 0: IDLE with `start` = 1; accepted at the rising edge ending cycle 0.
- Cycles 1..WIDTH: BUSY (full latency).
- Cycle WIDTH+1: DONE, with `done` = 1 and `product` valid (65 for WIDTH = 64).
- Cycle WIDTH+2: IDLE. The earliest next acceptance is at the end of this cycle.
- Every output is registered; there are no combinational paths from inputs to outputs.
- Reset values: `product` = 0, `done` = 0, `busy` = 0.

## Configuration
- `MUL_EARLY_TERM_EN` defined:
  - BUSY also exits to DONE when the next value of `b_reg` is 0.
  - The first BUSY cycle always executes.
  - DONE occurs in cycle k+1, where k = max(1, index of the highest set bit of `operand_b` + 1).
- `MUL_EARLY_TERM_EN` undefined:
  - Latency is fixed; DONE always occurs in cycle WIDTH+1.
  - The early-exit compare logic is absent.
- The product value is identical in both builds.

## Structure
- The state encodings `MUL_ST_IDLE`, `MUL_ST_BUSY`, `MUL_ST_DONE` (2-bit) go in the shared `constants.vh`, alongside the opcode and ALU constants.
- One combinational sub-module, `shift_add_step`, is natural:
  - Inputs: `acc`, `a_reg`, `b_reg`.
  - Outputs: next `acc`, `a`, `b`.
  - The top level holds the FSM, the counter and the registers.

## Test plan
- 3 × 5, macro off → `done` pulses in cycle 65 only, `product` = 15; `busy` high in cycles 1–65.
- 3 × 5, macro on → `done` in cycle 4, `product` = 15. x × 0 → `done` in cycle 2, `product` = 0.
- 0xFFFF_FFFF_FFFF_FFFD (−3) × 7 → `product` = 0xFFFF_FFFF_FFFF_FFEB. 0xFFFF_FFFF_FFFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE (overflow truncated).
- `start` held high with operands changed in cycle 10 → result still uses the cycle-0 operands; no re-acceptance until cycle WIDTH+2.
- `rst_n` pulsed low mid-cycle at cycle 20 of a 12 × 12 operation → `product` = 0, `busy` = 0 immediately; no `done`; a new 6 × 7 started afterwards gives 42.
- Back-to-back: start 2 × 9, drop `start` in the DONE cycle, raise it again in the next IDLE with 4 × 4 → products 18 then 16, two separate single-cycle `done` pulses.
